// File: rtl/uart_pkg.sv
// Shared UART constants and transmit state encoding, also used by the matching receiver.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int CLOCKS_PER_BIT          = 1302;
  localparam int CLOCKS_WAIT_FOR_RECEIVE = 651;
  localparam int DATA_WIDTH              = 8;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;
`endif

  function automatic int timer_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; the head entry is visible on rd_data
// so the consumer can load it on the same edge that pops it.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_50MHz,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_reg;
  assign rd_data = mem_reg[rd_ptr_reg];

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
    end
  end

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk_50MHz) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in sync_fifo and a frame FSM drains them onto TXD.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLOCKS_PER_BIT = uart_pkg::CLOCKS_PER_BIT,
  parameter int FIFO_DEPTH     = 16,
  parameter int DATA_WIDTH     = uart_pkg::DATA_WIDTH
) (
  input  logic                          clk_50MHz,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  import uart_pkg::*;

  localparam int TW = timer_width(CLOCKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLOCKS_PER_BIT - 1);
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] INDEX_LAST = IW'(DATA_WIDTH - 1);

  tx_state_t             state_reg;
  logic [TW-1:0]         timer_reg;
  logic [IW-1:0]         index_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  txd_reg;
  logic                  busy_reg;
`ifdef UART_TX_PARITY_EN
  logic                  parity_reg;
`endif

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  bit_done;

  // Readiness depends only on the registered count, so a full FIFO refuses even on a popping cycle.
  assign wr_ready  = !fifo_full && !reset;
  assign fifo_push = wr_valid && wr_ready;
  assign overflow  = wr_valid && !wr_ready && !reset;
  assign fifo_pop  = (state_reg == TX_IDLE) && !fifo_empty && !reset;
  assign bit_done  = (timer_reg == TIMER_LAST);
  assign TXD       = txd_reg;
  assign busy      = busy_reg;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .wr_data   (wr_data),
    .rd_data   (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_reg  <= TX_IDLE;
      timer_reg  <= '0;
      index_reg  <= '0;
      shift_reg  <= '0;
      txd_reg    <= 1'b1;
      busy_reg   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        TX_IDLE: begin
          txd_reg <= 1'b1;
          if (fifo_pop) begin
            shift_reg  <= fifo_head;
`ifdef UART_TX_PARITY_EN
            parity_reg <= ^fifo_head;
`endif
            txd_reg    <= 1'b0;
            timer_reg  <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= TX_START;
          end
        end
        TX_START: begin
          if (bit_done) begin
            timer_reg <= '0;
            index_reg <= '0;
            txd_reg   <= shift_reg[0];
            state_reg <= TX_DATA;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        TX_DATA: begin
          if (bit_done) begin
            timer_reg <= '0;
            if (index_reg == INDEX_LAST) begin
`ifdef UART_TX_PARITY_EN
              txd_reg   <= parity_reg;
              state_reg <= TX_PARITY;
`else
              txd_reg   <= 1'b1;
              state_reg <= TX_STOP;
`endif
            end else begin
              // Bit 0 sits in shift_reg[0], so the next bit to drive is always in [1].
              index_reg <= index_reg + 1'b1;
              shift_reg <= shift_reg >> 1;
              txd_reg   <= shift_reg[1];
            end
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_done) begin
            timer_reg <= '0;
            txd_reg   <= 1'b1;
            state_reg <= TX_STOP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
`endif
        TX_STOP: begin
          if (bit_done) begin
            timer_reg <= '0;
            busy_reg  <= 1'b0;
            state_reg <= TX_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: begin
          txd_reg   <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued, a negedge monitor decodes TXD
// cycle by cycle against a slot-based frame model and tracks expected fifo occupancy.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int SLOTS = 11;
`else
  localparam int SLOTS = 10;
`endif
  localparam int FRAME = SLOTS * CPB;

  logic       clk_50MHz = 1'b0;
  logic       reset     = 1'b1;
  logic [7:0] wr_data   = 8'h00;
  logic       wr_valid  = 1'b0;
  logic       wr_ready;
  logic       TXD;
  logic       busy;
  logic [4:0] fifo_count;
  logic       overflow;

  uart_tx_fifo #(
    .CLOCKS_PER_BIT (CPB),
    .FIFO_DEPTH     (DEPTH),
    .DATA_WIDTH     (8)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .reset      (reset),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .TXD        (TXD),
    .busy       (busy),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] sb[$];
  int         accepted_total = 0;
  int         started        = 0;
  int         mon_pos        = -1;
  bit         gap_pending    = 1'b0;
  int         gap_cnt        = 0;
  logic [7:0] cur_byte       = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: slot 0 start, slots 1..8 data LSB first, optional parity slot, then stop.
  function automatic logic exp_bit(input logic [7:0] b, input int p);
    int slot;
    slot = p / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return ((b >> (slot - 1)) & 8'h01) != 8'h00;
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk_50MHz);
      if (reset) begin
        mon_pos        = -1;
        sb.delete();
        accepted_total = 0;
        started        = 0;
        gap_pending    = 1'b0;
        gap_cnt        = 0;
      end else begin
        if (mon_pos < 0) begin
          if (TXD == 1'b0) begin
            if (gap_pending) check("gap_idle_cycles", gap_cnt, 1);
            gap_pending = 1'b0;
            if (sb.size() == 0) begin
              check("unexpected_frame_txd", int'(TXD), 1);
            end else begin
              cur_byte = sb.pop_front();
              started++;
              mon_pos = 0;
            end
          end else begin
            check("idle_busy", int'(busy), 0);
            if (gap_pending) begin
              gap_cnt++;
              if (gap_cnt > 1) begin
                check("gap_idle_cycles", gap_cnt, 1);
                gap_pending = 1'b0;
              end
            end
          end
        end
        if (mon_pos >= 0) begin
          check("txd_bit", int'(TXD), int'(exp_bit(cur_byte, mon_pos)));
          check("frame_busy", int'(busy), 1);
          mon_pos++;
          if (mon_pos == FRAME) begin
            $display("frame data=%02h sent", cur_byte);
            mon_pos     = -1;
            gap_pending = (sb.size() > 0);
            gap_cnt     = 0;
          end
        end
        check("fifo_count", int'(fifo_count), accepted_total - started);
        check("wr_ready", int'(wr_ready), int'((accepted_total - started) < DEPTH));
      end
    end
  end

  // Call right after a rising edge; presents one byte for exactly one cycle.
  task automatic do_write(input logic [7:0] d, output bit acc);
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk_50MHz);
    #1;
    acc = ((accepted_total - started) < DEPTH);
    check("overflow", int'(overflow), int'(!acc));
    @(posedge clk_50MHz);
    if (acc) begin
      sb.push_back(d);
      accepted_total++;
    end
    $display("write data=%02h accepted=%0d", d, acc);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk_50MHz);
      #1;
      if (sb.size() == 0 && mon_pos < 0 && !busy && accepted_total == started) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_timeout", int'(done), 1);
    @(posedge clk_50MHz);
    #1;
  endtask

  task automatic wait_frame_start();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_50MHz);
      #1;
      if (mon_pos >= 0) begin
        seen = 1'b1;
        break;
      end
    end
    check("frame_start_timeout", int'(seen), 1);
    @(posedge clk_50MHz);
    #1;
  endtask

  initial begin
    bit acc;
    int n;
    int gap;
    bit flag;

    // Reset state, with a write attempt that must be neither accepted nor flagged
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    repeat (3) @(posedge clk_50MHz);
    @(negedge clk_50MHz);
    check("reset_txd", int'(TXD), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(fifo_count), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_wr_ready", int'(wr_ready), 0);
    @(posedge clk_50MHz);
    #1;
    wr_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge clk_50MHz);
    #1;

    // Single byte into an idle block
    do_write(8'h55, acc);
    @(negedge clk_50MHz);
    check("latency_txd_still_high", int'(TXD), 1);
    @(negedge clk_50MHz);
    check("latency_txd_start", int'(TXD), 0);
    n = 0;
    for (int k = 0; k < 200 && busy; k++) begin
      n++;
      @(negedge clk_50MHz);
    end
    check("busy_cycles", n, FRAME);
    wait_idle();

    // Back-to-back writes
    do_write(8'hA3, acc);
    do_write(8'h0F, acc);
    @(negedge clk_50MHz);
    check("b2b_count_after_pop", int'(fifo_count), 1);
    wait_idle();

    // Fill to full while a frame is on the line, then one more write
    do_write(8'($urandom), acc);
    wait_frame_start();
    n = 0;
    for (int k = 0; k < 17; k++) begin
      do_write(8'($urandom), acc);
      if (acc) n++;
    end
    check("full_accepted", n, 16);
    @(negedge clk_50MHz);
    check("full_count", int'(fifo_count), 16);
    check("full_wr_ready", int'(wr_ready), 0);
    wait_idle();

    // Push on the very edge where IDLE pops, with three entries queued
    do_write(8'h11, acc);
    wait_frame_start();
    do_write(8'h22, acc);
    do_write(8'h33, acc);
    do_write(8'h44, acc);
    flag = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk_50MHz);
      #1;
      if (gap_pending && gap_cnt == 0 && mon_pos < 0) begin
        flag = 1'b1;
        break;
      end
    end
    check("simul_sync", int'(flag), 1);
    @(posedge clk_50MHz);
    #1;
    do_write(8'h55, acc);
    @(negedge clk_50MHz);
    check("simul_count", int'(fifo_count), 3);
    wait_idle();

    // Parity-relevant bytes (plain frames when parity is disabled)
    do_write(8'h07, acc);
    do_write(8'h03, acc);
    wait_idle();

    // Reset at cycle 12 of a 0x00 frame with bytes still queued
    do_write(8'h00, acc);
    wait_frame_start();
    do_write(8'hC3, acc);
    do_write(8'h3C, acc);
    repeat (8) @(posedge clk_50MHz);
    #1;
    reset = 1'b1;
    @(negedge clk_50MHz);
    check("midreset_wr_ready", int'(wr_ready), 0);
    @(posedge clk_50MHz);
    #1;
    reset = 1'b0;
    @(negedge clk_50MHz);
    check("midreset_txd", int'(TXD), 1);
    check("midreset_count", int'(fifo_count), 0);
    check("midreset_busy", int'(busy), 0);
    flag = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk_50MHz);
      if (TXD !== 1'b1 || busy !== 1'b0) flag = 1'b0;
    end
    check("post_reset_idle", int'(flag), 1);
    @(posedge clk_50MHz);
    #1;

    // Randomized traffic with bursts and long pauses
    for (int i = 0; i < 50; i++) begin
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 2));
      if (gap > 0) begin
        repeat (gap) @(posedge clk_50MHz);
        #1;
      end
      do_write(8'($urandom), acc);
    end
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
